// File: rtl/mem_pkg.sv
// Shared definitions for the burst RAM: controller state encoding and
// the supported read-latency range.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 2;

endpackage

// File: rtl/ram_sp_be.sv
// Single-port storage array with per-byte write enables and a registered
// read port (one cycle from address to data).
module ram_sp_be #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 15
) (
  input  logic                clk,
  input  logic                en,
  input  logic                we,
  input  logic [DATA_W/8-1:0] be,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   wdata,
  output logic [DATA_W-1:0]   rdata
);

  localparam int BE_W = DATA_W / 8;

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // NOTE: the array and rdata carry no reset; contents survive a controller
  // reset, and a reset branch would stop the array mapping onto RAM macros.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < BE_W; i++) begin
          if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/mem_burst_ram.sv
// Burst-command front end for a byte-enable RAM: accepts read/write bursts,
// streams write beats in and read beats out with RD_LAT cycles of latency.
module mem_burst_ram
  import mem_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 15,
  parameter int RD_LAT = 1,
  parameter int LEN_W  = 8
) (
  input  logic                clka,
  input  logic                rsta,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_we,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [LEN_W-1:0]    cmd_len,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic [DATA_W/8-1:0] wr_be,
  output logic                rd_valid,
  output logic [DATA_W-1:0]   rd_data,
  output logic                rd_last,
  output logic                busy,
  output logic                wrap
);

  state_t              state;
  logic [ADDR_W-1:0]   addr;
  logic [LEN_W-1:0]    cnt;
  logic                rolled;
  logic                wr_fire;
  logic                issue;
  logic                last_beat;
  logic [DATA_W-1:0]   ram_rdata;
  logic                v1;
  logic                l1;

  assign wr_fire   = wr_valid & wr_ready;
  assign issue     = (state == READ);
  assign last_beat = (cnt == '0);
  // rolled marks that the counter reached 0 by incrementing, so a burst
  // that merely starts at address 0 does not pulse wrap.
  assign wrap      = (wr_fire | issue) & rolled & (addr == '0);

  // NOTE: address/count/rolled are pure datapath reloaded on every command,
  // so they need no reset; only control state below is reset.
  always_ff @(posedge clka) begin
    if (cmd_valid && cmd_ready) begin
      addr   <= cmd_addr;
      cnt    <= cmd_len;
      rolled <= 1'b0;
    end else if (wr_fire || issue) begin
      addr <= addr + 1'b1;
      cnt  <= cnt - 1'b1;
      if (addr == '1) rolled <= 1'b1;
    end
  end

  always_ff @(posedge clka) begin
    if (rsta) begin
      state     <= IDLE;
      cmd_ready <= 1'b1;
      wr_ready  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (cmd_valid) begin
          state     <= cmd_we ? WRITE : READ;
          cmd_ready <= 1'b0;
          wr_ready  <= cmd_we;
          busy      <= 1'b1;
        end
        WRITE: if (wr_valid && last_beat) begin
          state     <= IDLE;
          cmd_ready <= 1'b1;
          wr_ready  <= 1'b0;
          busy      <= 1'b0;
        end
        // With single-cycle latency the final beat lands in the cycle after
        // the last issue, which must already be IDLE, so DRAIN is skipped.
        READ: if (last_beat) begin
          if (RD_LAT == RD_LAT_MIN) begin
            state     <= IDLE;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
          end else begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          state     <= IDLE;
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clka) begin
    if (rsta) begin
      v1 <= 1'b0;
      l1 <= 1'b0;
    end else begin
      v1 <= issue;
      l1 <= issue & last_beat;
    end
  end

  ram_sp_be #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clka),
    .en    (wr_fire | issue),
    .we    (wr_fire),
    .be    (wr_be),
    .addr  (addr),
    .wdata (wr_data),
    .rdata (ram_rdata)
  );

  if (RD_LAT >= RD_LAT_MAX) begin : g_lat2
    logic              v2;
    logic              l2;
    logic [DATA_W-1:0] d2;

    always_ff @(posedge clka) begin
      if (rsta) begin
        v2 <= 1'b0;
        l2 <= 1'b0;
      end else begin
        v2 <= v1;
        l2 <= l1;
      end
    end

    always_ff @(posedge clka) begin
      if (v1) d2 <= ram_rdata;
    end

    assign rd_valid = v2;
    assign rd_last  = l2;
    assign rd_data  = d2;
  end else begin : g_lat1
    assign rd_valid = v1;
    assign rd_last  = l1;
    assign rd_data  = ram_rdata;
  end

endmodule

// File: tb/tb_mem_burst_ram.sv
// Bench for mem_burst_ram: one instance at RD_LAT=1 and one at RD_LAT=2 share
// stimulus; a word-array model and cycle arithmetic predict every output.
module tb_mem_burst_ram;

  localparam int DEPTH = 1 << 15;

  logic        clka = 1'b0;
  logic        rsta = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_we = 1'b0;
  logic [14:0] cmd_addr = '0;
  logic [7:0]  cmd_len = '0;
  logic        wr_valid = 1'b0;
  logic [15:0] wr_data = '0;
  logic [1:0]  wr_be = '0;

  logic [1:0]  cmd_ready, wr_ready, rd_valid, rd_last, busy, wrap;
  logic [15:0] rd_data [2];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [15:0] mdl [DEPTH];
  logic [15:0] wq_data [$];
  logic [1:0]  wq_be [$];
  logic [15:0] rq [$];

  always #5 clka = ~clka;
  always @(posedge clka) cyc <= cyc + 1;

  mem_burst_ram #(.DATA_W(16), .ADDR_W(15), .RD_LAT(1), .LEN_W(8)) dut1 (
    .clka(clka), .rsta(rsta), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready[0]),
    .cmd_we(cmd_we), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready[0]), .wr_data(wr_data), .wr_be(wr_be),
    .rd_valid(rd_valid[0]), .rd_data(rd_data[0]), .rd_last(rd_last[0]),
    .busy(busy[0]), .wrap(wrap[0])
  );

  mem_burst_ram #(.DATA_W(16), .ADDR_W(15), .RD_LAT(2), .LEN_W(8)) dut2 (
    .clka(clka), .rsta(rsta), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready[1]),
    .cmd_we(cmd_we), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready[1]), .wr_data(wr_data), .wr_be(wr_be),
    .rd_valid(rd_valid[1]), .rd_data(rd_data[1]), .rd_last(rd_last[1]),
    .busy(busy[1]), .wrap(wrap[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic send_cmd(input bit we, input logic [14:0] a, input logic [7:0] l,
                          output int c0);
    bit ok = 1'b0;
    c0 = -1;
    cmd_valid = 1'b1; cmd_we = we; cmd_addr = a; cmd_len = l;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clka);
      if (cmd_ready == 2'b11) begin ok = 1'b1; c0 = cyc; end
      @(posedge clka); #1;
    end
    cmd_valid = 1'b0;
    check("cmd_accept", 32'(ok), 32'd1);
  endtask

  // Writes the beats queued in wq_data/wq_be starting at a; gap inserts an
  // idle cycle before each beat.
  task automatic write_burst(input logic [14:0] a, input bit gap);
    int c0, n, exp_wraps;
    int wraps [2];
    bit ok;
    logic [14:0] wa;
    n = wq_data.size();
    wraps = '{0, 0};
    exp_wraps = 0;
    send_cmd(1'b1, a, 8'(n - 1), c0);
    for (int k = 0; k < n; k++) begin
      if (gap) begin
        wr_valid = 1'b0;
        @(negedge clka);
        check("busy_ready_in_gap", {busy, wr_ready}, 4'b1111);
        for (int d = 0; d < 2; d++) wraps[d] += int'(wrap[d]);
        @(posedge clka); #1;
      end
      wr_valid = 1'b1; wr_data = wq_data[k]; wr_be = wq_be[k];
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
        @(negedge clka);
        for (int d = 0; d < 2; d++) wraps[d] += int'(wrap[d]);
        if (wr_ready == 2'b11) ok = 1'b1;
        @(posedge clka); #1;
      end
      check("wr_accept", 32'(ok), 32'd1);
      wa = a + 15'(k);
      for (int b = 0; b < 2; b++)
        if (wq_be[k][b]) mdl[wa][8*b +: 8] = wq_data[k][8*b +: 8];
      if (wa == 15'd0 && k > 0) exp_wraps++;
    end
    wr_valid = 1'b0;
    @(negedge clka);
    check("wr_done_busy", busy, 2'b00);
    check("wr_done_cmd_ready", cmd_ready, 2'b11);
    for (int d = 0; d < 2; d++) begin
      wraps[d] += int'(wrap[d]);
      check($sformatf("wr_wraps%0d", d), wraps[d], exp_wraps);
    end
    wq_data.delete();
    wq_be.delete();
    @(posedge clka); #1;
  endtask

  // Beat k of a read whose first issue is cycle t appears at t+k+latency;
  // busy stays high until the cycle of the last beat.
  task automatic read_burst(input logic [14:0] a, input logic [7:0] l);
    int c0, t, k, exp_wraps;
    int lat [2];
    int wraps [2];
    bit ev;
    logic [14:0] ra;
    lat = '{1, 2};
    wraps = '{0, 0};
    exp_wraps = 0;
    rq.delete();
    for (int j = 1; j <= int'(l); j++) if (15'(a + 15'(j)) == 15'd0) exp_wraps++;
    send_cmd(1'b0, a, l, c0);
    t = c0 + 1;
    for (int cy = t; cy <= t + int'(l) + 3; cy++) begin
      @(negedge clka);
      for (int d = 0; d < 2; d++) begin
        k = cyc - t - lat[d];
        ev = (k >= 0) && (k <= int'(l));
        check($sformatf("rd_valid%0d", d), 32'(rd_valid[d]), 32'(ev));
        if (ev) begin
          ra = a + 15'(k);
          check($sformatf("rd_data%0d", d), 32'(rd_data[d]), 32'(mdl[ra]));
          check($sformatf("rd_last%0d", d), 32'(rd_last[d]), 32'(k == int'(l)));
        end
        check($sformatf("rd_busy%0d", d), 32'(busy[d]), 32'(cyc < t + int'(l) + lat[d]));
        wraps[d] += int'(wrap[d]);
      end
      if (rd_valid[0]) rq.push_back(rd_data[0]);
    end
    for (int d = 0; d < 2; d++) check($sformatf("rd_wraps%0d", d), wraps[d], exp_wraps);
    @(posedge clka); #1;
  endtask

  typedef struct {
    bit          we;
    logic [14:0] addr;
    logic [1:0]  be;
    logic [15:0] data;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs [8];
  logic [15:0] burst_words [5];
  logic [15:0] gap_words [4];

  initial begin
    int c0, s, l, strays;
    logic [14:0] a;

    vecs[0] = '{1'b1, 15'h0010, 2'b11, 16'hFFFF, 16'h0000};
    vecs[1] = '{1'b1, 15'h0010, 2'b01, 16'h1234, 16'h0000};
    vecs[2] = '{1'b0, 15'h0010, 2'b00, 16'h0000, 16'hFF34};
    vecs[3] = '{1'b1, 15'h0020, 2'b11, 16'hA5A5, 16'h0000};
    vecs[4] = '{1'b1, 15'h0020, 2'b10, 16'h3C77, 16'h0000};
    vecs[5] = '{1'b0, 15'h0020, 2'b00, 16'h0000, 16'h3CA5};
    vecs[6] = '{1'b1, 15'h0020, 2'b00, 16'hFFFF, 16'h0000};
    vecs[7] = '{1'b0, 15'h0020, 2'b00, 16'h0000, 16'h3CA5};
    burst_words = '{16'hAAAA, 16'h5555, 16'hCCCC, 16'h3333, 16'h1111};
    gap_words   = '{16'h0F0F, 16'hF0F0, 16'h00FF, 16'hFF00};

    repeat (3) @(posedge clka);
    #1;
    @(negedge clka);
    check("rst_cmd_ready", cmd_ready, 2'b11);
    check("rst_wr_ready", wr_ready, 2'b00);
    check("rst_rd_valid", rd_valid, 2'b00);
    check("rst_rd_last", rd_last, 2'b00);
    check("rst_busy", busy, 2'b00);
    check("rst_wrap", wrap, 2'b00);
    @(posedge clka); #1;
    rsta = 1'b0;
    @(posedge clka); #1;

    // Fill a 512-word window straddling the top/bottom of the address space
    // with two maximum-length bursts.
    for (int i = 0; i < 256; i++) begin wq_data.push_back(16'($urandom)); wq_be.push_back(2'b11); end
    write_burst(15'h7F00, 1'b0);
    for (int i = 0; i < 256; i++) begin wq_data.push_back(16'($urandom)); wq_be.push_back(2'b11); end
    write_burst(15'h0000, 1'b0);

    foreach (vecs[i]) begin
      if (vecs[i].we) begin
        wq_data.push_back(vecs[i].data); wq_be.push_back(vecs[i].be);
        write_burst(vecs[i].addr, 1'b0);
      end else begin
        read_burst(vecs[i].addr, 8'd0);
        check("vec_beats", rq.size(), 1);
        if (rq.size() == 1) check($sformatf("vec%0d_data", i), 32'(rq[0]), 32'(vecs[i].exp));
      end
    end

    for (int i = 0; i < 5; i++) begin wq_data.push_back(burst_words[i]); wq_be.push_back(2'b11); end
    write_burst(15'h0001, 1'b0);
    read_burst(15'h0001, 8'd4);
    check("burst_beats", rq.size(), 5);
    for (int i = 0; i < 5 && i < rq.size(); i++)
      check($sformatf("burst_word%0d", i), 32'(rq[i]), 32'(burst_words[i]));

    wq_data = '{16'hBEEF, 16'hCAFE}; wq_be = '{2'b11, 2'b11};
    write_burst(15'h7FFF, 1'b0);
    read_burst(15'h0000, 8'd0);
    check("wrap_read_beats", rq.size(), 1);
    if (rq.size() == 1) check("wrap_read_data", 32'(rq[0]), 32'h0000CAFE);
    read_burst(15'h7FFE, 8'd2);

    read_burst(15'h0040, 8'd2);

    for (int i = 0; i < 4; i++) begin wq_data.push_back(gap_words[i]); wq_be.push_back(2'b11); end
    write_burst(15'h0050, 1'b1);
    read_burst(15'h0050, 8'd3);
    for (int i = 0; i < 4 && i < rq.size(); i++)
      check($sformatf("gap_word%0d", i), 32'(rq[i]), 32'(gap_words[i]));

    read_burst(15'h7F80, 8'd255);

    send_cmd(1'b0, 15'h7F10, 8'd20, c0);
    repeat (4) begin @(posedge clka); #1; end
    rsta = 1'b1;
    @(posedge clka); #1;
    rsta = 1'b0;
    @(negedge clka);
    check("rst_mid_rd_valid", rd_valid, 2'b00);
    check("rst_mid_busy", busy, 2'b00);
    check("rst_mid_cmd_ready", cmd_ready, 2'b11);
    strays = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clka);
      strays += int'(rd_valid[0]) + int'(rd_valid[1]);
    end
    check("rst_mid_strays", strays, 0);
    @(posedge clka); #1;
    read_burst(15'h7F10, 8'd5);

    for (int i = 0; i < 40; i++) begin
      s = int'($urandom_range(0, 500));
      l = int'($urandom_range(0, 15));
      if (s + l > 511) l = 511 - s;
      a = 15'h7F00 + 15'(s);
      if ($urandom_range(0, 1) == 1) begin
        for (int j = 0; j <= l; j++) begin
          wq_data.push_back(16'($urandom));
          wq_be.push_back(2'($urandom_range(0, 3)));
        end
        write_burst(a, $urandom_range(0, 3) == 0);
      end else begin
        read_burst(a, 8'(l));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
